// File: rtl/loader_package.sv
// Shared types and sizing for the boot-time ROM loader.
// Word width is fixed at four bytes; the ROM depth follows ADDR_W.
package loader_package;

    localparam int ADDR_W    = 5;
    localparam int WORD_W    = 32;
    localparam int MAX_WORDS = 2**ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERR
    } LOAD_STATE;

endpackage

// File: rtl/rom_loader_word_assembler.sv
// Packs bytes MSB-first into 32-bit words for the ROM loader.
// Only three bytes are stored; the fourth is merged on the FULL cycle.
module word_assembler (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        SHIFT,
    input  logic        CLR,
    input  logic [7:0]  BYTE_IN,
    output logic [31:0] WORD_OUT,
    output logic        FULL
);

    logic [23:0] head;
    logic [1:0]  count;

    assign WORD_OUT = {head, BYTE_IN};
    assign FULL     = SHIFT && (count == 2'd3);

    // Shift accepted bytes in and count them modulo four.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            head  <= '0;
            count <= '0;
        end else if (CLR) begin
            head  <= '0;
            count <= '0;
        end else if (SHIFT) begin
            head  <= {head[15:0], BYTE_IN};
            count <= count + 2'd1;
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Boot loader: byte stream in, ROM word writes out, CPU reset release.
// CPU stays in reset until a full image passes its checksum.
module rom_loader
    import loader_package::*;
(
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              START,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    output logic              RX_READY,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [WORD_W-1:0] WR_DATA,
    output logic              CPU_RST_N,
    output logic              DONE,
    output logic              ERROR
);

    LOAD_STATE         state;
    logic [ADDR_W-1:0] last_addr;
    logic [7:0]        checksum;
    logic              accept;
    logic              begin_load;
    logic              asm_shift;
    logic              asm_full;
    logic [31:0]       asm_word;

    assign accept     = RX_VALID && RX_READY;
    assign asm_shift  = accept && (state == DATA);
    assign begin_load = START && ((state == IDLE) ||
                                  (state == loader_package::DONE) ||
                                  (state == ERR));

    word_assembler u_asm (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .SHIFT    (asm_shift),
        .CLR      (begin_load),
        .BYTE_IN  (RX_DATA),
        .WORD_OUT (asm_word),
        .FULL     (asm_full)
    );

    // Load sequencer with registered handshake, write and status outputs.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            RX_READY  <= 1'b0;
            WR_EN     <= 1'b0;
            WR_ADDR   <= '0;
            WR_DATA   <= '0;
            CPU_RST_N <= 1'b0;
            DONE      <= 1'b0;
            ERROR     <= 1'b0;
            last_addr <= '0;
            checksum  <= '0;
        end else begin
            WR_EN <= 1'b0;
            unique case (state)
                IDLE, loader_package::DONE, ERR: begin
                    if (START) begin
                        state     <= HEADER;
                        RX_READY  <= 1'b1;
                        DONE      <= 1'b0;
                        ERROR     <= 1'b0;
                        CPU_RST_N <= 1'b0;
                        WR_ADDR   <= '0;
                        checksum  <= '0;
                    end
                end
                HEADER: begin
                    if (accept) begin
                        if (RX_DATA == 8'd0 ||
                            int'(RX_DATA) > MAX_WORDS) begin
                            state    <= ERR;
                            RX_READY <= 1'b0;
                            ERROR    <= 1'b1;
                        end else begin
                            state     <= DATA;
                            last_addr <= ADDR_W'(RX_DATA - 8'd1);
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        checksum <= checksum + RX_DATA;
                        if (asm_full) begin
                            state    <= WRITE;
                            RX_READY <= 1'b0;
                            WR_EN    <= 1'b1;
                            WR_DATA  <= WORD_W'(asm_word);
                        end
                    end
                end
                WRITE: begin
                    RX_READY <= 1'b1;
                    if (WR_ADDR == last_addr) begin
                        state <= CHECK;
                    end else begin
                        state   <= DATA;
                        WR_ADDR <= WR_ADDR + 1'b1;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        RX_READY <= 1'b0;
                        if (RX_DATA == checksum) begin
                            state     <= loader_package::DONE;
                            DONE      <= 1'b1;
                            CPU_RST_N <= 1'b1;
                        end else begin
                            state <= ERR;
                            ERROR <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    RX_READY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Randomized bench for rom_loader against a stream-level reference model.
// Expected writes and status come from the stream format alone.
module tb_rom_loader;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic [7:0]  RX_DATA = 8'h00;
    logic        RX_VALID = 1'b0;
    logic        RX_READY;
    logic        WR_EN;
    logic [4:0]  WR_ADDR;
    logic [31:0] WR_DATA;
    logic        CPU_RST_N;
    logic        DONE;
    logic        ERROR;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  stream[$];
    logic [36:0] exp_q[$];
    logic [36:0] got_q[$];
    bit          exp_ok;
    int          n_used;
    logic [31:0] last_wr = '0;
    logic        prev_en = 1'b0;

    rom_loader dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .START     (START),
        .RX_DATA   (RX_DATA),
        .RX_VALID  (RX_VALID),
        .RX_READY  (RX_READY),
        .WR_EN     (WR_EN),
        .WR_ADDR   (WR_ADDR),
        .WR_DATA   (WR_DATA),
        .CPU_RST_N (CPU_RST_N),
        .DONE      (DONE),
        .ERROR     (ERROR)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor: capture writes, check pulse shape and data hold.
    always @(negedge CLOCK) begin
        if (!RESET) begin
            last_wr = '0;
            prev_en = 1'b0;
        end else if (WR_EN) begin
            got_q.push_back({WR_ADDR, WR_DATA});
            check("rdy_in_write", 64'(RX_READY), 64'd0);
            check("wr_pulse", 64'(prev_en), 64'd0);
            last_wr = WR_DATA;
            prev_en = 1'b1;
        end else begin
            check("wr_data_hold", 64'(WR_DATA), 64'(last_wr));
            prev_en = 1'b0;
        end
    end

    task automatic model();
        int n;
        int sum;
        logic [31:0] word;
        exp_q.delete();
        n = int'(stream[0]);
        if (n == 0 || n > 32) begin
            exp_ok = 1'b0;
            n_used = 1;
        end else begin
            sum = 0;
            for (int w = 0; w < n; w++) begin
                word = '0;
                for (int k = 0; k < 4; k++) begin
                    word = {word[23:0], stream[1 + 4*w + k]};
                    sum += int'(stream[1 + 4*w + k]);
                end
                exp_q.push_back({5'(w), word});
            end
            exp_ok = (stream[1 + 4*n] == 8'(sum));
            n_used = 4*n + 2;
        end
    endtask

    task automatic make_stream(input int n, input bit good);
        int sum;
        logic [7:0] b;
        sum = 0;
        stream.delete();
        stream.push_back(8'(n));
        if (n >= 1 && n <= 32) begin
            for (int i = 0; i < 4*n; i++) begin
                b = 8'($urandom);
                stream.push_back(b);
                sum += int'(b);
            end
            if (good)
                stream.push_back(8'(sum));
            else
                stream.push_back(8'(sum + int'($urandom_range(1, 255))));
        end
    endtask

    task automatic load_s1(input logic [7:0] cks);
        stream = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                   8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h38};
        stream[9] = cks;
    endtask

    task automatic send_byte(input logic [7:0] b,
                             input int gap,
                             input bit noise);
        int budget;
        while (int'($urandom_range(99)) < gap) begin
            RX_VALID = 1'b0;
            @(negedge CLOCK);
        end
        RX_DATA  = b;
        RX_VALID = 1'b1;
        if (noise && $urandom_range(3) == 0)
            START = 1'b1;
        budget = 0;
        while (!RX_READY && budget < 100) begin
            @(negedge CLOCK);
            START = 1'b0;
            budget++;
        end
        if (!RX_READY) begin
            check("accept_timeout", 64'd0, 64'd1);
            RX_VALID = 1'b0;
            START    = 1'b0;
            return;
        end
        @(negedge CLOCK);
        START    = 1'b0;
        RX_VALID = 1'b0;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        @(negedge CLOCK);
        START = 1'b0;
        check("start_cpu_rst", 64'(CPU_RST_N), 64'd0);
        check("start_done_clr", 64'(DONE), 64'd0);
        check("start_err_clr", 64'(ERROR), 64'd0);
    endtask

    task automatic run_load(input int gap, input bit noise);
        model();
        got_q.delete();
        pulse_start();
        for (int i = 0; i < n_used; i++)
            send_byte(stream[i], gap, noise && i > 0);
        check("done_lat", 64'(DONE), 64'(exp_ok));
        check("error_lat", 64'(ERROR), 64'(!exp_ok));
        check("cpu_rst_lat", 64'(CPU_RST_N), 64'(exp_ok));
        repeat (3) @(negedge CLOCK);
        check("rdy_after", 64'(RX_READY), 64'd0);
        check("done_sticky", 64'(DONE), 64'(exp_ok));
        check("wr_count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("wr_word", 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdy"}, 64'(RX_READY), 64'd0);
        check({tag, "_wen"}, 64'(WR_EN), 64'd0);
        check({tag, "_addr"}, 64'(WR_ADDR), 64'd0);
        check({tag, "_data"}, 64'(WR_DATA), 64'd0);
        check({tag, "_cpu"}, 64'(CPU_RST_N), 64'd0);
        check({tag, "_done"}, 64'(DONE), 64'd0);
        check({tag, "_err"}, 64'(ERROR), 64'd0);
    endtask

    task automatic release_reset();
        @(negedge CLOCK);
        @(posedge CLOCK);
        #2 RESET = 1'b1;
        @(negedge CLOCK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge CLOCK);
        check_reset_vals("rst");
        release_reset();
        check_reset_vals("idle");

        load_s1(8'h38);
        run_load(0, 1'b0);

        load_s1(8'h39);
        run_load(0, 1'b0);

        stream = '{8'h00};
        run_load(0, 1'b0);
        stream = '{8'h21};
        run_load(0, 1'b0);

        make_stream(32, 1'b1);
        run_load(10, 1'b0);
        check("full_last_addr", 64'(got_q[got_q.size()-1][36:32]), 64'd31);

        load_s1(8'h38);
        run_load(40, 1'b1);

        load_s1(8'h38);
        model();
        got_q.delete();
        pulse_start();
        for (int i = 0; i < 6; i++)
            send_byte(stream[i], 0, 1'b0);
        @(posedge CLOCK);
        #2 RESET = 1'b0;
        #1 check_reset_vals("midrst");
        release_reset();
        load_s1(8'h38);
        run_load(20, 1'b0);

        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(9) == 0)
                make_stream(int'($urandom_range(33, 255)), 1'b1);
            else
                make_stream(int'($urandom_range(1, 32)),
                            $urandom_range(9) < 7);
            run_load(int'($urandom_range(0, 50)), 1'($urandom_range(1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
